// File: rtl/capture_ctrl_if.sv
// Capture port bundle: sampler/trigger inputs in, RAM write port and status out.
// master drives strobes/config (host side); slave is capture_ctrl.
interface capture_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            wrt_smpl;
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            set_capture_done;

  modport master (
    output wrt_smpl,
    output run,
    output capture_done,
    output triggered,
    output trig_pos,
    input  we,
    input  waddr,
    input  armed,
    input  set_capture_done
  );

  modport slave (
    input  wrt_smpl,
    input  run,
    input  capture_done,
    input  triggered,
    input  trig_pos,
    output we,
    output waddr,
    output armed,
    output set_capture_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: owns the shared RAMqueue write port, arms the trigger
// once enough pre-trigger history is stored, counts post-trigger samples.
// Ports: clk, rst_n (async, active low), bus (capture_ctrl_if.slave):
//   in  wrt_smpl, run, capture_done, triggered, trig_pos
//   out we, waddr, armed, set_capture_done
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [LOG2:0]   ENT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES-1);

  logic [1:0]      state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2:0]   smpl_q, smpl_d;
  logic [LOG2-1:0] trig_q, trig_d;
  logic            armed_q, armed_d;
  logic            scd_q, scd_d;

  logic [LOG2-1:0] tp;
  logic [LOG2-1:0] waddr_nx;
  logic [LOG2-1:0] trig_inc;
  logic            we;

  always_comb begin
    tp = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
    waddr_nx = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;
    trig_inc = trig_q + 1'b1;
    we = bus.wrt_smpl & bus.run &
         ((state_q == PRE) | (state_q == POST));
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    smpl_d  = smpl_q;
    trig_d  = trig_q;
    scd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run && !bus.capture_done) begin
          smpl_d  = '0;
          trig_d  = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else begin
          if (we) begin
            waddr_d = waddr_nx;
            smpl_d  = (smpl_q == ENT) ? ENT : smpl_q + 1'b1;
          end
          // a sample in the trigger cycle still counts as pre-trigger
          if (bus.triggered && armed_q) begin
            trig_d = '0;
            if (tp == '0) begin
              state_d = DONE;
              scd_d   = 1'b1;
            end else begin
              state_d = POST;
            end
          end
        end
      end
      POST: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (we) begin
          waddr_d = waddr_nx;
          trig_d  = trig_inc;
          if (trig_inc == tp) begin
            state_d = DONE;
            scd_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.capture_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // armed follows the post-edge sample count so it is registered cleanly
  always_comb begin
    armed_d = 1'b0;
    unique case (state_d)
      PRE:     armed_d = ((smpl_d + {1'b0, tp}) >= ENT);
      POST:    armed_d = 1'b1;
      default: armed_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      smpl_q  <= '0;
      trig_q  <= '0;
      armed_q <= 1'b0;
      scd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      smpl_q  <= smpl_d;
      trig_q  <= trig_d;
      armed_q <= armed_d;
      scd_q   <= scd_d;
    end
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr_q;
  assign bus.armed            = armed_q;
  assign bus.set_capture_done = scd_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed testbench for capture_ctrl.
// Models cmd_cfg by raising capture_done when the done pulse is seen.
module tb_capture_ctrl;

  logic clk;
  logic rst_n;

  capture_ctrl_if #(.LOG2(9)) ifc ();

  capture_ctrl #(
    .ENTRIES(384),
    .LOG2   (9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int tests;
  int fails;
  int wr_cnt;
  int pulse_cnt;
  int bad_addr;
  int max_wa;
  int last_wa;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.we) begin
      wr_cnt++;
      last_wa = int'(ifc.waddr);
      if (int'(ifc.waddr) >= 384) bad_addr++;
      if (int'(ifc.waddr) > max_wa) max_wa = int'(ifc.waddr);
    end
    if (ifc.set_capture_done) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.set_capture_done) ifc.capture_done = 1'b1;
  endtask

  task automatic strobe(input int gap, input logic trg);
    logic sv;
    repeat (gap-1) tick();
    sv = ifc.triggered;
    ifc.wrt_smpl  = 1'b1;
    ifc.triggered = sv | trg;
    tick();
    ifc.wrt_smpl  = 1'b0;
    ifc.triggered = sv;
  endtask

  task automatic test_reset();
    int pc;
    rst_n = 1'b0;
    ifc.wrt_smpl = 0;
    ifc.run = 0;
    ifc.capture_done = 0;
    ifc.triggered = 0;
    ifc.trig_pos = '0;
    repeat (3) tick();
    tests++;
    if (ifc.waddr !== 9'd0) begin
      fails++;
      $display("FAIL rst_waddr: got %0d want 0", ifc.waddr);
    end
    tests++;
    if (ifc.we !== 1'b0 || ifc.armed !== 1'b0 ||
        ifc.set_capture_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_outs: we=%b armed=%b scd=%b want 0", ifc.we,
               ifc.armed, ifc.set_capture_done);
    end
    rst_n = 1'b1;
    pc = 0;
    repeat (100) begin
      tick();
      if (ifc.set_capture_done) pc++;
    end
    tests++;
    if (pc != 0 || wr_cnt != 0) begin
      fails++;
      $display("FAIL idle_quiet: pulses=%0d writes=%0d want 0/0", pc, wr_cnt);
    end
    tests++;
    if (ifc.waddr !== 9'd0 || ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL idle_state: waddr=%0d armed=%b want 0/0", ifc.waddr,
               ifc.armed);
    end
  endtask

  task automatic test_normal();
    int w0, p0, n;
    ifc.trig_pos = 9'd84;
    ifc.run = 1'b1;
    tick();
    w0 = wr_cnt;
    p0 = pulse_cnt;
    for (int i = 1; i <= 299; i++) strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL arm_299: got %b want 0", ifc.armed);
    end
    strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b1) begin
      fails++;
      $display("FAIL arm_300: got %b want 1", ifc.armed);
    end
    for (int i = 301; i <= 349; i++) strobe(4, 1'b0);
    strobe(4, 1'b1);
    tests++;
    if (wr_cnt - w0 != 350) begin
      fails++;
      $display("FAIL pre_writes: got %0d want 350", wr_cnt - w0);
    end
    n = 0;
    while (ifc.capture_done == 1'b0 && n < 200) begin
      strobe(4, 1'b0);
      n++;
    end
    tests++;
    if (n != 84) begin
      fails++;
      $display("FAIL post_writes: got %0d want 84", n);
    end
    tests++;
    if (ifc.waddr !== 9'd50) begin
      fails++;
      $display("FAIL final_waddr: got %0d want 50", ifc.waddr);
    end
    tick();
    tests++;
    if (pulse_cnt - p0 != 1 || ifc.set_capture_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: pulses=%0d scd=%b want 1/0",
               pulse_cnt - p0, ifc.set_capture_done);
    end
    repeat (5) strobe(4, 1'b0);
    tests++;
    if (wr_cnt - w0 != 434 || ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL done_quiet: writes=%0d armed=%b want 434/0",
               wr_cnt - w0, ifc.armed);
    end
    ifc.run = 1'b0;
  endtask

  task automatic test_tp0();
    int w0, p0;
    rst_n = 1'b0;
    #2;
    tests++;
    if (ifc.waddr !== 9'd0 || ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: waddr=%0d armed=%b want 0/0", ifc.waddr,
               ifc.armed);
    end
    ifc.run = 1'b0;
    ifc.capture_done = 1'b0;
    ifc.triggered = 1'b0;
    ifc.trig_pos = 9'd0;
    tick();
    rst_n = 1'b1;
    tick();
    ifc.triggered = 1'b1;
    ifc.run = 1'b1;
    tick();
    w0 = wr_cnt;
    p0 = pulse_cnt;
    for (int i = 1; i <= 383; i++) strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL tp0_arm383: got %b want 0", ifc.armed);
    end
    strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b1 || ifc.set_capture_done !== 1'b0) begin
      fails++;
      $display("FAIL tp0_arm384: armed=%b scd=%b want 1/0", ifc.armed,
               ifc.set_capture_done);
    end
    tick();
    tests++;
    if (ifc.set_capture_done !== 1'b1 || ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL tp0_pulse: scd=%b armed=%b want 1/0",
               ifc.set_capture_done, ifc.armed);
    end
    tick();
    tests++;
    if (ifc.set_capture_done !== 1'b0 || pulse_cnt - p0 != 1) begin
      fails++;
      $display("FAIL tp0_once: scd=%b pulses=%0d want 0/1",
               ifc.set_capture_done, pulse_cnt - p0);
    end
    tests++;
    if (wr_cnt - w0 != 384 || ifc.waddr !== 9'd0) begin
      fails++;
      $display("FAIL tp0_addr: writes=%0d waddr=%0d want 384/0",
               wr_cnt - w0, ifc.waddr);
    end
    ifc.triggered = 1'b0;
    ifc.run = 1'b0;
  endtask

  task automatic test_early_trig();
    int w0, p0, n;
    ifc.capture_done = 1'b0;
    tick();
    ifc.trig_pos = 9'd100;
    ifc.run = 1'b1;
    tick();
    w0 = wr_cnt;
    p0 = pulse_cnt;
    bad_addr = 0;
    max_wa = 0;
    for (int i = 1; i <= 300; i++) begin
      strobe(4, (i == 10 || i == 283 || i == 300));
      if (i == 283) begin
        tests++;
        if (ifc.armed !== 1'b0 || pulse_cnt != p0) begin
          fails++;
          $display("FAIL early_ign: armed=%b pulses=%0d want 0/0",
                   ifc.armed, pulse_cnt - p0);
        end
      end
      if (i == 284) begin
        tests++;
        if (ifc.armed !== 1'b1) begin
          fails++;
          $display("FAIL early_arm: got %b want 1", ifc.armed);
        end
      end
    end
    n = 0;
    while (ifc.capture_done == 1'b0 && n < 200) begin
      strobe(4, 1'b0);
      n++;
    end
    tick();
    tests++;
    if (n != 100 || pulse_cnt - p0 != 1) begin
      fails++;
      $display("FAIL early_post: n=%0d pulses=%0d want 100/1", n,
               pulse_cnt - p0);
    end
    tests++;
    if (ifc.waddr !== 9'd16 || wr_cnt - w0 != 400) begin
      fails++;
      $display("FAIL wrap_addr: waddr=%0d writes=%0d want 16/400",
               ifc.waddr, wr_cnt - w0);
    end
    tests++;
    if (bad_addr != 0 || max_wa != 383) begin
      fails++;
      $display("FAIL wrap_range: bad=%0d max=%0d want 0/383", bad_addr,
               max_wa);
    end
    ifc.run = 1'b0;
  endtask

  task automatic test_abort();
    int w0, p0;
    ifc.capture_done = 1'b0;
    tick();
    ifc.trig_pos = 9'd10;
    ifc.run = 1'b1;
    tick();
    w0 = wr_cnt;
    p0 = pulse_cnt;
    for (int i = 1; i <= 380; i++) strobe(4, (i == 380));
    repeat (5) strobe(4, 1'b0);
    tests++;
    if (wr_cnt - w0 != 385 || ifc.waddr !== 9'd17) begin
      fails++;
      $display("FAIL abort_pre: writes=%0d waddr=%0d want 385/17",
               wr_cnt - w0, ifc.waddr);
    end
    repeat (3) tick();
    ifc.run = 1'b0;
    ifc.wrt_smpl = 1'b1;
    #1;
    tests++;
    if (ifc.we !== 1'b0) begin
      fails++;
      $display("FAIL abort_we: got %b want 0", ifc.we);
    end
    tick();
    ifc.wrt_smpl = 1'b0;
    repeat (3) tick();
    tests++;
    if (ifc.waddr !== 9'd17 || wr_cnt - w0 != 385 ||
        pulse_cnt != p0 || ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold: waddr=%0d wr=%0d pulses=%0d armed=%b",
               ifc.waddr, wr_cnt - w0, pulse_cnt - p0, ifc.armed);
    end
    ifc.run = 1'b1;
    tick();
    for (int i = 1; i <= 373; i++) strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL fresh_arm373: got %b want 0", ifc.armed);
    end
    strobe(4, 1'b0);
    tests++;
    if (ifc.armed !== 1'b1 || ifc.waddr !== 9'd7) begin
      fails++;
      $display("FAIL fresh_arm374: armed=%b waddr=%0d want 1/7",
               ifc.armed, ifc.waddr);
    end
  endtask

  task automatic test_done_hold();
    int w0, p0, n;
    strobe(4, 1'b1);
    n = 0;
    while (ifc.capture_done == 1'b0 && n < 200) begin
      strobe(4, 1'b0);
      n++;
    end
    tests++;
    if (n != 10 || ifc.waddr !== 9'd18) begin
      fails++;
      $display("FAIL hold_done: n=%0d waddr=%0d want 10/18", n, ifc.waddr);
    end
    tick();
    w0 = wr_cnt;
    p0 = pulse_cnt;
    repeat (250) strobe(4, 1'b0);
    tests++;
    if (wr_cnt != w0 || pulse_cnt != p0 || ifc.waddr !== 9'd18) begin
      fails++;
      $display("FAIL hold_quiet: wr=%0d pulses=%0d waddr=%0d want 0/0/18",
               wr_cnt - w0, pulse_cnt - p0, ifc.waddr);
    end
    ifc.capture_done = 1'b0;
    tick();
    tick();
    tests++;
    if (ifc.armed !== 1'b0) begin
      fails++;
      $display("FAIL resume_arm: got %b want 0", ifc.armed);
    end
    strobe(4, 1'b0);
    tests++;
    if (wr_cnt - w0 != 1 || last_wa != 18 || ifc.waddr !== 9'd19) begin
      fails++;
      $display("FAIL resume_wr: wr=%0d at=%0d waddr=%0d want 1/18/19",
               wr_cnt - w0, last_wa, ifc.waddr);
    end
    ifc.run = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    wr_cnt = 0;
    pulse_cnt = 0;
    bad_addr = 0;
    max_wa = 0;
    last_wa = 0;
    rst_n = 1'b0;
    ifc.wrt_smpl = 1'b0;
    ifc.run = 1'b0;
    ifc.capture_done = 1'b0;
    ifc.triggered = 1'b0;
    ifc.trig_pos = '0;
    test_reset();
    test_normal();
    test_tp0();
    test_early_trig();
    test_abort();
    test_done_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the logic-analyzer sample RAMs. It owns the shared write port of the five channel RAMqueues: it generates `we`/`waddr` on each decimated sample strobe and arms the trigger logic once enough pre-trigger history is stored. After the trigger it counts `trig_pos` post-trigger samples and then pulses `set_capture_done` to cmd_cfg. On completion `waddr` points at the oldest sample, which is where a dump starts.

## Interface
- `ENTRIES`, 384, depth of each channel RAMqueue.
- `LOG2`, 9, address width; must satisfy 2^LOG2 >= ENTRIES.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wrt_smpl`  in  1  one-cycle strobe per decimated sample, from the sample clock/decimator.
- `run`  in  1  capture enable, from the TrigCfg run bit.
- `capture_done`  in  1  capture_done bit from TrigCfg; it stays high until the host clears it.
- `triggered`  in  1  trigger event from the trigger logic; level or pulse.
- `trig_pos`  in  LOG2  number of samples to keep after the trigger.
- `we`  out  1  write enable, common to all five RAMqueues.
- `waddr`  out  LOG2  write address, common to all RAMqueues; also fed to cmd_cfg.
- `armed`  out  1  pre-trigger buffer is satisfied; the trigger logic may fire.
- `set_capture_done`  out  1  one-cycle pulse to cmd_cfg.

## Operation
- Parameter rule: an effective trig_pos `tp` = min(trig_pos, ENTRIES-1).
- **IDLE**
  - `we`=0.
  - On `run`=1 and `capture_done`=0: clear `smpl_cnt` and `trig_cnt`, go to PRE.
  - `waddr` is not cleared.
- **PRE**
  - On `wrt_smpl`: write to `waddr` (`we`=1), then `waddr` advances.
  - `smpl_cnt` increments and saturates at ENTRIES. It is LOG2+1 bits wide.
  - `armed` = (`smpl_cnt` + `tp` >= ENTRIES), computed in LOG2+1 bits.
  - On `triggered`=1 while `armed`=1:
    - if `tp`==0, go to DONE and pulse `set_capture_done`;
    - otherwise go to POST with `trig_cnt`=0.
  - `triggered` while not armed is ignored.
- **POST**
  - On `wrt_smpl`: write, `waddr` advances, `trig_cnt` increments.
  - On the write where `trig_cnt`+1 == `tp`: go to DONE and pulse `set_capture_done`.
  - `armed` is held at 1.
- **DONE**
  - `we`=0, `armed`=0, `waddr` frozen. `waddr` now addresses the oldest stored sample.
  - Go to IDLE when `capture_done`=0 (host cleared the flag).
- **Address wrap:** `waddr` == ENTRIES-1 advances to 0. It never takes a value >= ENTRIES.
- **Abort:** `run`=0 in PRE or POST goes to IDLE next edge.
  - No write occurs in that cycle.
  - No `set_capture_done` pulse.
  - `waddr` is held.

## Timing
- Reset values:
  - state = IDLE;
  - `waddr`=0, `smpl_cnt`=0, `trig_cnt`=0;
  - `we`=0, `armed`=0, `set_capture_done`=0.
- `we` is combinational: `wrt_smpl` & (state==PRE | state==POST) & `run`. The write uses the current `waddr`, and `waddr` updates on the same posedge.
- `armed` is registered and reflects `smpl_cnt` after the update edge.
- `set_capture_done` is registered and high for exactly one cycle, the cycle after the final post-trigger write edge. For `tp`==0 it is the cycle after the trigger edge.
- `triggered` and `wrt_smpl` in the same cycle in PRE with `armed`=1: the sample is a pre-trigger sample (counts in `smpl_cnt`, not `trig_cnt`), and state goes to POST.
- `run` falling in the same cycle as the final POST write: abort wins; no write and no pulse.
- Reset asserted mid-capture: immediately forces all reset values, regardless of clock.
- `trig_pos` is sampled continuously and is static during a capture (host contract).
- Latency from first `wrt_smpl` to `armed`: ENTRIES-`tp` strobes, plus 1 clk.

## Test plan
- Reset with all inputs 0, then release → `waddr`=0, `we`=0, `armed`=0, no pulse for 100 clks.
- `run`=1, `trig_pos`=84, strobe every 4 clks →
  - `armed` rises after strobe 300;
  - `triggered` pulsed at strobe 350 → exactly 84 further writes, one `set_capture_done` pulse;
  - final `waddr`=(350+84) mod 384=50.
- `trig_pos`=0, `triggered` held high from start →
  - `armed` after 384 strobes;
  - DONE next edge with no post writes, pulse once;
  - `waddr`=0 (wrapped).
- `triggered` pulsed before `armed` → ignored; capture completes only on a later armed trigger. Also check that `waddr` passes 383→0 with no write to address 384.
- `run` dropped mid-POST with `trig_pos`=10 after 5 post writes → IDLE, `we`=0, no pulse, `waddr` held. Then `capture_done`=0 with `run`=1 → fresh PRE with `smpl_cnt`=0 and `armed`=0.
- DONE with `capture_done` held high for 1000 clks and strobes running → no writes. Then clear `capture_done` → IDLE → PRE, writes resume from the frozen `waddr`.
